// File: rtl/seq_multdiv_unit_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// FSM encodings, iteration counts, $rstatus exception codes and helpers.
package seq_multdiv_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   localparam int ALU_W          = 33;
   localparam int MULT_STEPS_DEF = 16;
   localparam int DIV_STEPS_DEF  = 32;

   localparam logic [3:0] EXC_CODE_MUL = 4'd4;
   localparam logic [3:0] EXC_CODE_DIV = 4'd5;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/seq_multdiv_unit_addsub33.sv
// 33-bit adder/subtractor shared by the Booth multiply and non-restoring divide paths.
// ovf_o flags signed overflow so callers can recover the true 34-bit sign.
module seq_multdiv_unit_addsub33
   import seq_multdiv_unit_pkg::*;
(
   input  logic [ALU_W-1:0] a_i,
   input  logic [ALU_W-1:0] b_i,
   input  logic             sub_i,
   output logic [ALU_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [ALU_W-1:0] b_eff;

   assign b_eff = b_i ^ {ALU_W{sub_i}};
   assign sum_o = a_i + b_eff + {{(ALU_W-1){1'b0}}, sub_i};
   assign ovf_o = (a_i[ALU_W-1] == b_eff[ALU_W-1]) && (sum_o[ALU_W-1] != a_i[ALU_W-1]);

endmodule

// File: rtl/seq_multdiv_unit.sv
// Iterative 32-bit signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// One start pulse launches an op; data_resultRDY strobes for one cycle on completion.
module seq_multdiv_unit
   import seq_multdiv_unit_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MULT_STEPS = MULT_STEPS_DEF,
   parameter int DIV_STEPS  = DIV_STEPS_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS - 1);
   localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

   md_state_e   state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] acc_q, acc_d;      // Booth P, or divide remainder
   logic [31:0] lo_q, lo_d;        // Booth Q, or dividend shifting into quotient
   logic [32:0] opnd_q, opnd_d;    // sign-extended multiplicand, or |divisor|
   logic        qm1_q, qm1_d;
   logic        neg_q, neg_d;
   logic        dovf_q, dovf_d;
   logic [31:0] res_q, res_d;
   logic        exc_q, exc_d;

   logic [32:0] add_a, add_b, add_sum;
   logic        add_sub, add_ovf;
   logic [2:0]  booth;
   logic        sign34;
   logic [32:0] mul_acc, prod_hi;
   logic [31:0] mul_lo, div_lo, quot;
   logic        mul_ovf;

   seq_multdiv_unit_addsub33 u_addsub (
      .a_i   (add_a),
      .b_i   (add_b),
      .sub_i (add_sub),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

   always_comb begin
      booth   = {lo_q[1:0], qm1_q};
      add_a   = acc_q;
      add_b   = '0;
      add_sub = 1'b0;
      if (state_q == DIV) begin
         add_a   = {acc_q[31:0], lo_q[31]};
         add_b   = opnd_q;
         add_sub = ~acc_q[32];
      end else begin
         case (booth)
            3'b001, 3'b010: add_b = opnd_q;
            3'b011:         add_b = {opnd_q[31:0], 1'b0};
            3'b100: begin
               add_b   = {opnd_q[31:0], 1'b0};
               add_sub = 1'b1;
            end
            3'b101, 3'b110: begin
               add_b   = opnd_q;
               add_sub = 1'b1;
            end
            default: add_b = '0;
         endcase
      end
   end

   // P +/- 2M can exceed 33 bits; the overflow flag restores the true sign for the shift.
   assign sign34  = add_sum[32] ^ add_ovf;
   assign mul_acc = {sign34, sign34, add_sum[32:2]};
   assign mul_lo  = {add_sum[1:0], lo_q[31:2]};
   assign prod_hi = {mul_acc[31:0], mul_lo[31]};
   assign mul_ovf = ~((prod_hi == '0) | (prod_hi == '1));
   assign div_lo  = {lo_q[30:0], ~add_sum[32]};
   assign quot    = neg_q ? (~div_lo + 32'd1) : div_lo;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      qm1_d   = qm1_q;
      neg_d   = neg_q;
      dovf_d  = dovf_q;
      res_d   = res_q;
      exc_d   = exc_q;
      if (ctrl_MULT || ctrl_DIV) begin
         cnt_d  = '0;
         acc_d  = '0;
         qm1_d  = 1'b0;
         neg_d  = data_operandA[31] ^ data_operandB[31];
         dovf_d = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
         if (ctrl_MULT) begin
            state_d = MULT;
            opnd_d  = {data_operandA[31], data_operandA};
            lo_d    = data_operandB;
         end else if (data_operandB == '0) begin
            state_d = DONE;
            res_d   = '0;
            exc_d   = 1'b1;
         end else begin
            state_d = DIV;
            opnd_d  = {1'b0, mag32(data_operandB)};
            lo_d    = mag32(data_operandA);
         end
      end else begin
         case (state_q)
            MULT: begin
               acc_d = mul_acc;
               lo_d  = mul_lo;
               qm1_d = lo_q[1];
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == MULT_LAST) begin
                  state_d = DONE;
                  res_d   = mul_lo;
                  exc_d   = mul_ovf;
               end
            end
            DIV: begin
               acc_d = add_sum;
               lo_d  = div_lo;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == DIV_LAST) begin
                  state_d = DONE;
                  res_d   = quot;
                  exc_d   = dovf_q;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      qm1_q  <= qm1_d;
      neg_q  <= neg_d;
      dovf_q <= dovf_d;
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_seq_multdiv_unit.sv
// Directed plus model-driven checks of seq_multdiv_unit through an expected-result queue.
module tb_seq_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_operandA, data_operandB;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        exc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   seq_multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic expect_op(input string tag, input logic [31:0] res, input logic exc, input int lat);
      exp_t e;
      e.tag = tag;
      e.res = res;
      e.exc = exc;
      e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_done();
      exp_t e;
      int   n;
      bit   seen;
      n    = 0;
      seen = 1'b0;
      while (n <= 40) begin
         if (data_resultRDY) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock);
         #1;
         n++;
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.tag, "_rdy"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check({e.tag, "_result"}, data_result, e.res);
         check({e.tag, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
         check({e.tag, "_latency"}, 32'(n), 32'(e.lat));
         @(posedge clock);
         #1;
         check({e.tag, "_rdy_single"}, {31'd0, data_resultRDY}, 32'd0);
      end
   endtask

   function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
      longint      p;
      logic [63:0] pu;
      int          q;
      if (is_mul) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         pu  = p;
         r   = pu[31:0];
         e   = !((pu[63:31] == '0) || (pu[63:31] == '1));
         lat = 16;
      end else if (b == 32'd0) begin
         r   = 32'd0;
         e   = 1'b1;
         lat = 0;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r   = 32'h8000_0000;
         e   = 1'b1;
         lat = 32;
      end else begin
         q   = $signed(a) / $signed(b);
         r   = q;
         e   = 1'b0;
         lat = 32;
      end
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          rdy_cnt;
      logic [31:0] a, b, r;
      logic        e;
      int          lat;
      bit          is_mul;

      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_result", data_result, 32'd0);
      check("reset_exc", {31'd0, data_exception}, 32'd0);
      check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

      expect_op("mul_7x-3", 32'hFFFF_FFEB, 1'b0, 16);
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_done();

      expect_op("mul_ovf", 32'd0, 1'b1, 16);
      start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
      wait_done();

      expect_op("mul_max_x1", 32'h7FFF_FFFF, 1'b0, 16);
      start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
      wait_done();

      expect_op("mul_min_x2", 32'd0, 1'b1, 16);
      start_op(1'b1, 1'b0, 32'h8000_0000, 32'd2);
      wait_done();

      expect_op("mul_min_x_min", 32'd0, 1'b1, 16);
      start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
      wait_done();

      expect_op("div_-7/2", 32'hFFFF_FFFD, 1'b0, 32);
      start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done();

      expect_op("div_100/-7", 32'hFFFF_FFF2, 1'b0, 32);
      start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
      wait_done();

      expect_op("div_by_zero", 32'd0, 1'b1, 0);
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      wait_done();

      expect_op("div_min/-1", 32'h8000_0000, 1'b1, 32);
      start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();

      // Reset eight cycles into a multiply abandons it.
      start_op(1'b1, 1'b0, 32'd123, 32'd456);
      repeat (7) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midreset_result", data_result, 32'd0);
      check("midreset_exc", {31'd0, data_exception}, 32'd0);
      rdy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (data_resultRDY) rdy_cnt++;
         @(posedge clock);
         #1;
      end
      check("midreset_no_rdy", 32'(rdy_cnt), 32'd0);

      expect_op("mul_6x7", 32'd42, 1'b0, 16);
      start_op(1'b1, 1'b0, 32'd6, 32'd7);
      wait_done();

      // A multiply issued mid-divide restarts the unit.
      start_op(1'b0, 1'b1, 32'd9, 32'd3);
      repeat (9) @(posedge clock);
      #1;
      expect_op("restart_mul_4x5", 32'd20, 1'b0, 16);
      start_op(1'b1, 1'b0, 32'd4, 32'd5);
      wait_done();
      rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (data_resultRDY) rdy_cnt++;
         @(posedge clock);
         #1;
      end
      check("restart_no_extra_rdy", 32'(rdy_cnt), 32'd0);

      expect_op("both_high_is_mul", 32'hFFFF_FFE2, 1'b0, 16);
      start_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd6);
      wait_done();

      for (int i = 0; i < 8; i++) begin
         is_mul = (i % 2) == 0;
         a      = $urandom;
         if (is_mul) b = (i < 4) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
         else        b = 32'($urandom_range(1, 5000)) * (((i % 4) == 1) ? 32'hFFFF_FFFF : 32'd1);
         model(is_mul, a, b, r, e, lat);
         expect_op(is_mul ? "rand_mul" : "rand_div", r, e, lat);
         start_op(is_mul, !is_mul, a, b);
         wait_done();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
